// File: rtl/adder_pipe_seg.sv
// Pipelined segmented ripple-carry adder with valid/ready handshake and full backpressure.
// Define APPROX_LSB_EN to compute the low APPROX_BITS sum bits as a | b with no carry chain.
module adder_pipe_seg #(
  parameter int WIDTH       = 32,
  parameter int SEG         = 8,
  parameter int APPROX_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0 || STAGES < 1 || STAGES > 16 ||
      APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_badParams
    $error("adder_pipe_seg: illegal WIDTH/SEG/APPROX_BITS combination");
  end

  logic [WIDTH-1:0] w_aIn;
  logic [WIDTH-1:0] w_bIn;
  logic             w_cinIn;

`ifdef APPROX_LSB_EN
  // Folding a|b into operand A and zeroing B's low bits makes the exact pipeline
  // produce the OR result there with no carry escaping into the upper bits.
  localparam logic [WIDTH-1:0] LOW_MASK = (APPROX_BITS >= WIDTH) ? '1 :
                                          ((WIDTH'(1) << APPROX_BITS) - WIDTH'(1));
  logic w_unusedCin;
  assign w_unusedCin = cin;
  assign w_aIn   = (a & ~LOW_MASK) | ((a | b) & LOW_MASK);
  assign w_bIn   = b & ~LOW_MASK;
  assign w_cinIn = 1'b0;
`else
  assign w_aIn   = a;
  assign w_bIn   = b;
  assign w_cinIn = cin;
`endif

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];

  logic [WIDTH-1:0]  w_stageA     [STAGES];
  logic [WIDTH-1:0]  w_stageB     [STAGES];
  logic [WIDTH-1:0]  w_stageSumIn [STAGES];
  logic [SEG:0]      w_segRes     [STAGES];
  logic [STAGES-1:0] w_stageCin;
  logic [STAGES-1:0] w_stageValid;
  logic              w_stall;

  assign w_stall  = r_valid[STAGES-1] & ~out_ready;
  assign in_ready = ~w_stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_stageA[k]     = w_aIn;
      assign w_stageB[k]     = w_bIn;
      assign w_stageCin[k]   = w_cinIn;
      assign w_stageValid[k] = in_valid;
      assign w_stageSumIn[k] = '0;
    end else begin : g_rest
      assign w_stageA[k]     = r_a[k-1];
      assign w_stageB[k]     = r_b[k-1];
      assign w_stageCin[k]   = r_carry[k-1];
      assign w_stageValid[k] = r_valid[k-1];
      assign w_stageSumIn[k] = r_sum[k-1];
    end
    assign w_segRes[k] = {1'b0, w_stageA[k][k*SEG +: SEG]} +
                         {1'b0, w_stageB[k][k*SEG +: SEG]} +
                         (SEG+1)'(w_stageCin[k]);
  end

  // Every stage shifts together unless the output slot is stalled; bubbles move like data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_carry <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k]               <= w_stageValid[k];
        r_carry[k]               <= w_segRes[k][SEG];
        r_sum[k]                 <= w_stageSumIn[k];
        r_sum[k][k*SEG +: SEG]   <= w_segRes[k][SEG-1:0];
        r_a[k]                   <= w_stageA[k];
        r_b[k]                   <= w_stageB[k];
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_carry[STAGES-1];

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Self-checking bench for adder_pipe_seg: directed corner cases plus a randomized
// handshake stream compared against a slot-level arithmetic model (honours APPROX_LSB_EN).
module tb_adder_pipe_seg;

  localparam int WIDTH       = 32;
  localparam int SEG         = 8;
  localparam int APPROX_BITS = 8;
  localparam int ST          = WIDTH / SEG;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checkCount = 0;
  int passCount  = 0;

  logic           mValid [ST];
  logic [WIDTH:0] mRes   [ST];

  adder_pipe_seg #(.WIDTH(WIDTH), .SEG(SEG), .APPROX_BITS(APPROX_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Reference result {cout, sum} straight from the arithmetic definition.
  function automatic logic [WIDTH:0] refAdd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
`ifdef APPROX_LSB_EN
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   hi;
    m  = (APPROX_BITS >= WIDTH) ? '1 : ((WIDTH'(1) << APPROX_BITS) - WIDTH'(1));
    hi = {1'b0, x & ~m} + {1'b0, y & ~m};
    return hi | {1'b0, (x | y) & m};
`else
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
`endif
  endfunction

  task automatic clearModel();
    for (int k = 0; k < ST; k++) begin
      mValid[k] = 1'b0;
      mRes[k]   = '0;
    end
  endtask

  // One clock: compare against the model mid-cycle, advance the model, return just after the edge.
  task automatic stepCycle();
    logic stall;
    @(negedge clk);
    stall = mValid[ST-1] && !out_ready;
    checkOutput("out_valid", {63'd0, out_valid}, {63'd0, mValid[ST-1]});
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, !stall});
    if (mValid[ST-1]) begin
      checkOutput("sum", {32'd0, sum}, {32'd0, mRes[ST-1][WIDTH-1:0]});
      checkOutput("cout", {63'd0, cout}, {63'd0, mRes[ST-1][WIDTH]});
    end
    if (!stall) begin
      for (int k = ST-1; k > 0; k--) begin
        mValid[k] = mValid[k-1];
        mRes[k]   = mRes[k-1];
      end
      mValid[0] = in_valid;
      mRes[0]   = refAdd(a, b, cin);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic c, input logic ordy);
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
    stepCycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    clearModel();
    #1;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_sum", {32'd0, sum}, 64'd0);
    checkOutput("rst_cout", {63'd0, cout}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef APPROX_LSB_EN
    // Carry ripples through every segment.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    for (int i = 0; i < ST-1; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t1_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t1_sum", {32'd0, sum}, 64'h0);
    checkOutput("t1_cout", {63'd0, cout}, 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t2_sum0", {31'd0, cout, sum}, 64'h0_0000_0004);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t2_sum1", {31'd0, cout, sum}, 64'h0_8000_0000);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t2_sum2", {31'd0, cout, sum}, 64'h1_0000_0000);
    checkOutput("t2_valid", {63'd0, out_valid}, 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
`else
    applyStimulus(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0100, 32'h0000_0F00, 1'b0, 1'b1);
    for (int i = 0; i < ST-2; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t6_sum0", {31'd0, cout, sum}, 64'h0_0000_00FF);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("t6_sum1", {31'd0, cout, sum}, 64'h0_0000_1000);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
`endif

    // Backpressure: head result held while new operands are offered and refused.
    applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0);
    for (int i = 0; i < ST-2; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("bp_sum", {31'd0, cout, sum}, {31'd0, refAdd(32'h10, 32'h20, 1'b0)});
      applyStimulus(1'b1, $urandom, $urandom, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("bp_next_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("bp_next_sum", {31'd0, cout, sum}, {31'd0, refAdd(32'h5, 32'h6, 1'b1)});
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < ST; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset between edges while results are in flight.
    applyStimulus(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    for (int i = 0; i < ST-2; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mid_rst_sum", {32'd0, sum}, 64'd0);
    checkOutput("mid_rst_cout", {63'd0, cout}, 64'd0);
    checkOutput("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    clearModel();
    for (int i = 0; i < ST+2; i++) applyStimulus(1'b0, '0, '0, 1'b0, ($urandom_range(0, 1) == 1));

    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < ST+1; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/adder_pipe_seg.md
Name: adder_pipe_seg

Overview:
Parametrised pipelined ripple-carry adder. It is the next generation of the small 3-bit carry-in/carry-out adder partitions. Operands of WIDTH bits are split into SEG-bit segments, one segment per pipeline stage, and the carry is registered between stages. It has a valid/ready handshake with full backpressure and sits in datapath partitions where wide adds must meet timing. An optional approximate low-order mode supports accuracy/area trade-off experiments.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of SEG.
SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG (1..16).
APPROX_BITS, 8, number of LSBs computed approximately; used only with APPROX_LSB_EN; 0..WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in into bit 0.
out_valid  output  1  sum/cout valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: clk and rst only, rst asynchronous, active-high. It clears every stage valid bit, every carry register and sum to 0, and cout to 0, so out_valid = 0 and in_ready = 1 after reset. Reset mid-operation discards all in-flight operations. No result from before reset appears afterwards.
- Pipeline: stage k (0..STAGES-1) adds a[k*SEG +: SEG] + b[k*SEG +: SEG] + carry_k, where carry_0 = cin and carry_k = registered carry of stage k-1.
- Each stage registers its SEG result bits, its carry, a valid bit, and the not-yet-added upper operand segments. Lower completed result bits travel with the operation.
- Output register = last stage. sum is the concatenated segment results. cout is the carry of stage STAGES-1.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall (combinational).
- When stall = 0, all stages advance one position each cycle. Stage 0 loads (in_valid & in_ready).
- When stall = 1, every stage holds, and sum/cout/out_valid stay bit-stable.
- Latency: STAGES cycles from an accepting edge to out_valid = 1, with no stalls. Throughput is 1 result/cycle.
- Bubbles are not compressed. Invalid slots advance like valid ones.
- Simultaneous out_valid & out_ready & in_valid in the same cycle: the result leaves, all stages shift, and the new operand is accepted. No lost or duplicated result.
- Operands are sampled only on the accepting edge. Changes to a/b/cin at other times have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Signed use is valid because sum is two's-complement identical; overflow detection is the user's job.
- SEG = WIDTH (STAGES = 1): a single registered adder with latency 1.

Optional Feature:
APPROX_LSB_EN
- Defined: bits [APPROX_BITS-1:0] of sum are a | b (bitwise, no carry chain). cin is ignored. No carry propagates from bit APPROX_BITS-1 into bit APPROX_BITS. Upper bits are an exact add with carry-in 0. Segment boundaries, latency and handshake are unchanged. APPROX_BITS = 0 gives exact behaviour with cin forced to 0.
- Undefined: fully exact addition. APPROX_BITS is ignored.

Test Plan:
1. WIDTH=32, SEG=8, out_ready=1: a=0xFFFFFFFF, b=0x00000001, cin=0 -> 4 cycles later out_valid=1, sum=0x00000000, cout=1 (carry ripples through all 4 stages).
2. Back-to-back: 3 consecutive accepts (0x1+0x2 cin1, 0x7FFFFFFF+0x1 cin0, 0x80000000+0x80000000 cin0) -> on consecutive cycles sum=0x4/cout0, 0x80000000/cout0, 0x0/cout1, in order.
3. Backpressure: a result is valid and out_ready held 0 for 5 cycles -> in_ready=0, sum/cout/out_valid constant. Raise out_ready -> result consumed once; the next queued result follows the next cycle.
4. Reset mid-flight: accept 2 ops, assert rst for 1 cycle asynchronously between edges -> out_valid drops immediately, sum=0, and no stale result appears afterwards.
5. Random: 10k random a/b/cin with random in_valid/out_ready -> output stream equals the (a+b+cin) reference model stream in order, with no drops.
6. APPROX_LSB_EN, APPROX_BITS=8: a=0x000000FF, b=0x00000001, cin=1 -> sum=0x000000FF, cout=0; a=0x00000100, b=0x00000F00 -> sum=0x00001000 (upper bits exact).
